// File: rtl/axi_cmd_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_cmd_master_pkg
// Purpose  : Shared types and constants for the AXI4 command master: the
//            controller state enum, fixed burst/cache attributes and the
//            AXI response codes, plus a response-severity helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axi_cmd_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AXI bursts may not cross a 4 KB page.
  localparam int PAGE_BYTES = 4096;

  // Response codes are ranked by their numeric value.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_cmd_master
// Purpose  : Turns single burst commands into AXI4 write (AW/W/B) or read
//            (AR/R) transactions, one burst outstanding at a time. Write data
//            comes from a valid/ready source stream, read data leaves on a
//            valid/ready sink stream. A one-cycle done pulse reports the worst
//            response seen (forced to SLVERR on 4 KB crossing, ID mismatch or
//            early rlast).
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            cmd_*                     - command handshake and burst fields
//            src_*                     - write-data input stream
//            snk_*                     - read-data output stream
//            done, done_resp           - completion pulse and response
//            m_axi_*                   - AXI4 master (AW, W, B, AR, R)
// Revision : 1.0 - initial release
// ============================================================================
module axi_cmd_master
  import axi_cmd_master_pkg::*;
#(
  parameter int G_DATAWIDTH = 32,
  parameter int G_ADDRWIDTH = 32,
  parameter int G_ID_WIDTH  = 4,
  parameter int G_WEWIDTH   = ((G_DATAWIDTH - 1) / 8) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  // command
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [G_ADDRWIDTH-1:0] cmd_addr,
  input  logic [7:0]             cmd_len,
  input  logic [G_ID_WIDTH-1:0]  cmd_id,
  // write-data stream
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [G_DATAWIDTH-1:0] src_data,
  input  logic [G_WEWIDTH-1:0]   src_strb,
  // read-data stream
  output logic                   snk_valid,
  input  logic                   snk_ready,
  output logic [G_DATAWIDTH-1:0] snk_data,
  output logic                   snk_last,
  // completion
  output logic                   done,
  output logic [1:0]             done_resp,
  // AW
  output logic [G_ID_WIDTH-1:0]  m_axi_awid,
  output logic [G_ADDRWIDTH-1:0] m_axi_awaddr,
  output logic [7:0]             m_axi_awlen,
  output logic [2:0]             m_axi_awsize,
  output logic [1:0]             m_axi_awburst,
  output logic                   m_axi_awlock,
  output logic [3:0]             m_axi_awcache,
  output logic [2:0]             m_axi_awprot,
  output logic [3:0]             m_axi_awqos,
  output logic [3:0]             m_axi_awregion,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  // W
  output logic [G_DATAWIDTH-1:0] m_axi_wdata,
  output logic [G_WEWIDTH-1:0]   m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  // B
  input  logic [G_ID_WIDTH-1:0]  m_axi_bid,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  // AR
  output logic [G_ID_WIDTH-1:0]  m_axi_arid,
  output logic [G_ADDRWIDTH-1:0] m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic                   m_axi_arlock,
  output logic [3:0]             m_axi_arcache,
  output logic [2:0]             m_axi_arprot,
  output logic [3:0]             m_axi_arqos,
  output logic [3:0]             m_axi_arregion,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  // R
  input  logic [G_ID_WIDTH-1:0]  m_axi_rid,
  input  logic [G_DATAWIDTH-1:0] m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
);

  localparam int                   SIZE_LOG2     = $clog2(G_WEWIDTH);
  localparam logic [G_ADDRWIDTH-1:0] ADDR_LSB_MASK = G_ADDRWIDTH'(G_WEWIDTH - 1);

  state_t                   state;
  logic                     cmd_ready_q;
  logic                     awvalid_q;
  logic                     arvalid_q;
  logic                     bready_q;
  logic                     done_q;
  logic [1:0]               resp_q;      // worst response seen so far
  logic                     err_q;       // sticky protocol error -> SLVERR
  logic [8:0]               beat_cnt;
  logic [G_ADDRWIDTH-1:0]   addr_q;
  logic [7:0]               len_q;
  logic [G_ID_WIDTH-1:0]    id_q;

  logic [G_ADDRWIDTH-1:0]   cmd_addr_al;
  logic [31:0]              page_end;
  logic                     crosses_page;
  logic                     w_fire;
  logic                     r_fire;
  logic                     w_is_last;

  // page_end is one past the last byte, measured from the start of the page.
  assign cmd_addr_al  = cmd_addr & ~ADDR_LSB_MASK;
  assign page_end     = 32'(cmd_addr_al[11:0]) +
                        (32'(cmd_len) + 32'd1) * 32'(G_WEWIDTH);
  assign crosses_page = page_end > 32'(PAGE_BYTES);

  assign w_is_last = (beat_cnt == {1'b0, len_q});
  assign w_fire    = (state == S_W) && src_valid && m_axi_wready;
  assign r_fire    = (state == S_R) && m_axi_rvalid && snk_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      resp_q      <= RESP_OKAY;
      err_q       <= 1'b0;
      beat_cnt    <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      id_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!cmd_ready_q) begin
            // first idle cycle after reset: start offering
            cmd_ready_q <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr_al;
            len_q       <= cmd_len;
            id_q        <= cmd_id;
            resp_q      <= RESP_OKAY;
            err_q       <= 1'b0;
            beat_cnt    <= '0;
            if (crosses_page) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else if (cmd_write) begin
              awvalid_q <= 1'b1;
              state     <= S_AW;
            end else begin
              arvalid_q <= 1'b1;
              state     <= S_AR;
            end
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            awvalid_q <= 1'b0;
            state     <= S_W;
          end
        end
        S_W: begin
          if (w_fire) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (w_is_last) begin
              bready_q <= 1'b1;
              state    <= S_B;
            end
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            resp_q   <= resp_max(resp_q, m_axi_bresp);
            err_q    <= err_q | (m_axi_bid != id_q);
            done_q   <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            state     <= S_R;
          end
        end
        S_R: begin
          if (r_fire) begin
            beat_cnt <= beat_cnt + 9'd1;
            resp_q   <= resp_max(resp_q, m_axi_rresp);
            // a short burst (rlast before beat len) is still an error
            err_q    <= err_q | (m_axi_rid != id_q) |
                        (m_axi_rlast && (beat_cnt != {1'b0, len_q}));
            if (m_axi_rlast) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          cmd_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign done_resp = err_q ? RESP_SLVERR : resp_q;

  assign m_axi_awid     = id_q;
  assign m_axi_awaddr   = addr_q;
  assign m_axi_awlen    = len_q;
  assign m_axi_awsize   = 3'(SIZE_LOG2);
  assign m_axi_awburst  = BURST_INCR;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = CACHE_DEFAULT;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_awqos    = 4'h0;
  assign m_axi_awregion = 4'h0;
  assign m_axi_awvalid  = awvalid_q;

  assign m_axi_wdata  = src_data;
  assign m_axi_wstrb  = src_strb;
  assign m_axi_wvalid = (state == S_W) && src_valid;
  assign m_axi_wlast  = (state == S_W) && w_is_last;
  assign src_ready    = (state == S_W) && m_axi_wready;
  assign m_axi_bready = bready_q;

  assign m_axi_arid     = id_q;
  assign m_axi_araddr   = addr_q;
  assign m_axi_arlen    = len_q;
  assign m_axi_arsize   = 3'(SIZE_LOG2);
  assign m_axi_arburst  = BURST_INCR;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = CACHE_DEFAULT;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arqos    = 4'h0;
  assign m_axi_arregion = 4'h0;
  assign m_axi_arvalid  = arvalid_q;

  assign snk_valid    = (state == S_R) && m_axi_rvalid;
  assign snk_data     = m_axi_rdata;
  assign snk_last     = (state == S_R) && m_axi_rlast;
  assign m_axi_rready = (state == S_R) && snk_ready;

endmodule
`default_nettype wire

// File: tb/tb_axi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_cmd_master
// Purpose  : Self-checking bench for axi_cmd_master. Directed scenarios plus
//            randomized bursts; the bench plays the AXI slave and the stream
//            endpoints and predicts addresses, beats and responses from the
//            burst rules directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_cmd_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int WE = 4;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [IW-1:0] cmd_id;
  logic src_valid, src_ready;
  logic [DW-1:0] src_data;
  logic [WE-1:0] src_strb;
  logic snk_valid, snk_ready, snk_last;
  logic [DW-1:0] snk_data;
  logic done;
  logic [1:0] done_resp;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock;
  logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion;
  logic awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata, rdata;
  logic [WE-1:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_cmd_master #(.G_DATAWIDTH(DW), .G_ADDRWIDTH(AW), .G_ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_strb(src_strb),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data), .snk_last(snk_last),
    .done(done), .done_resp(done_resp),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awregion(awregion),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arregion(arregion),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: last byte of the burst must stay in the start page.
  function automatic bit crosses(input logic [31:0] addr, input logic [7:0] len);
    int base;
    base = int'(addr[11:0]) & ~(WE - 1);
    return (base + (int'(len) + 1) * WE) > 4096;
  endfunction

  task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] id);
    bit acc;
    acc = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
    for (int k = 0; k < 20 && !acc; k++) begin
      #1;
      if (cmd_ready === 1'b1) acc = 1;
      step();
    end
    cmd_valid = 0;
    cmd_addr = $urandom; cmd_len = 8'($urandom); cmd_id = 4'($urandom);
    chk("cmd_accept", 64'(acc), 1);
  endtask

  task automatic check_cross();
    bit seen;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("cross_quiet", {awvalid, arvalid, wvalid, bready, rready}, 0);
      if (done === 1'b1 && !seen) begin
        seen = 1;
        chk("cross_resp", done_resp, 2);
      end
      step();
    end
    chk("cross_done", 64'(seen), 1);
  endtask

  task automatic finish_check(input logic [1:0] exp_resp);
    #1;
    chk("done_pulse", done, 1);
    chk("done_resp", done_resp, exp_resp);
    chk("done_cmd_ready", cmd_ready, 0);
    step();
    #1;
    chk("done_end", done, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    step();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input logic [1:0] b_resp, input bit bad_bid, input bit fixed_data,
                          input int abort_beat);
    logic [31:0] data [256];
    logic [3:0]  strb [256];
    logic [31:0] aligned;
    int beat, stall, dly;
    bit hold;
    for (int i = 0; i <= int'(len); i++) begin
      data[i] = fixed_data ? 32'hA0 + 32'(i) : $urandom;
      strb[i] = 4'($urandom);
    end
    aligned = addr & ~32'(WE - 1);
    issue_cmd(1'b1, addr, len, id);
    if (crosses(addr, len)) begin
      check_cross();
      return;
    end
    awready = 0;
    #1;
    chk("awvalid", awvalid, 1);
    chk("awaddr", awaddr, aligned);
    chk("awlen", awlen, len);
    chk("awid", awid, id);
    chk("aw_attr", {awsize, awburst, awcache, awlock, awprot, awqos, awregion},
        {3'd2, 2'b01, 4'b0011, 1'b0, 3'd0, 4'd0, 4'd0});
    chk("aw_no_ar", arvalid, 0);
    stall = $urandom_range(0, 2);
    for (int s = 0; s < stall; s++) begin
      step(); #1;
      chk("aw_hold", {awvalid, awaddr, awlen}, {1'b1, aligned, len});
    end
    awready = 1;
    step();
    awready = 0;
    beat = 0; hold = 0;
    for (int cyc = 0; cyc < 400 && beat <= int'(len); cyc++) begin
      src_valid = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      src_data = data[beat]; src_strb = strb[beat];
      wready = ($urandom_range(0, 3) != 0);
      if (abort_beat >= 0 && beat == abort_beat) begin
        src_valid = 1; wready = 1; rst = 1;
        step(); #1;
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst = 0; src_valid = 0; wready = 0;
        step(); #1;
        chk("rst_no_done", done, 0);
        step();
        return;
      end
      #1;
      chk("wvalid_pass", wvalid, src_valid);
      chk("src_ready_pass", src_ready, wready);
      chk("bready_in_w", bready, 0);
      if (src_valid && wready) begin
        chk("wdata", wdata, data[beat]);
        chk("wstrb", wstrb, strb[beat]);
        chk("wlast", wlast, (beat == int'(len)) ? 1 : 0);
        beat++;
        hold = 0;
      end else begin
        hold = src_valid;
      end
      step();
    end
    src_valid = 0; wready = 0;
    chk("w_beats", 64'(beat), 64'(int'(len) + 1));
    dly = $urandom_range(0, 2);
    for (int d = 0; d < dly; d++) begin
      #1; chk("bready_wait", bready, 1); step();
    end
    bvalid = 1; bid = bad_bid ? id ^ 4'h1 : id; bresp = b_resp;
    #1;
    chk("bready", bready, 1);
    step();
    bvalid = 0;
    finish_check(bad_bid ? 2'b10 : b_resp);
  endtask

  // resp_mode: 0 all OKAY, 1 random, 2 EXOKAY on beat 0 only
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                         input int nbeats, input bit bad_rid, input bit toggle_ready,
                         input int resp_mode);
    logic [31:0] d [256];
    logic [1:0]  rs [256];
    logic [31:0] aligned;
    logic [1:0]  mx, exp_resp;
    int beat, stall;
    bit hold;
    mx = 0;
    for (int i = 0; i < nbeats; i++) begin
      d[i] = $urandom;
      rs[i] = (resp_mode == 1) ? 2'($urandom) : ((resp_mode == 2 && i == 0) ? 2'b01 : 2'b00);
      if (rs[i] > mx) mx = rs[i];
    end
    exp_resp = (bad_rid || nbeats != int'(len) + 1) ? 2'b10 : mx;
    aligned = addr & ~32'(WE - 1);
    issue_cmd(1'b0, addr, len, id);
    if (crosses(addr, len)) begin
      check_cross();
      return;
    end
    arready = 0;
    #1;
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, aligned);
    chk("arlen", arlen, len);
    chk("arid", arid, id);
    chk("ar_attr", {arsize, arburst, arcache, arlock, arprot, arqos, arregion},
        {3'd2, 2'b01, 4'b0011, 1'b0, 3'd0, 4'd0, 4'd0});
    chk("ar_no_aw", awvalid, 0);
    stall = $urandom_range(0, 2);
    for (int s = 0; s < stall; s++) begin
      step(); #1;
      chk("ar_hold", {arvalid, araddr, arlen}, {1'b1, aligned, len});
    end
    arready = 1;
    step();
    arready = 0;
    beat = 0; hold = 0;
    for (int cyc = 0; cyc < 800 && beat < nbeats; cyc++) begin
      rvalid = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      rdata = d[beat]; rresp = rs[beat];
      rlast = (beat == nbeats - 1);
      rid = (bad_rid && beat == 0) ? id ^ 4'h2 : id;
      snk_ready = toggle_ready ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
      #1;
      chk("snk_valid_pass", snk_valid, rvalid);
      chk("rready_pass", rready, snk_ready);
      if (rvalid && snk_ready) begin
        chk("snk_data", snk_data, d[beat]);
        chk("snk_last", snk_last, (beat == nbeats - 1) ? 1 : 0);
        beat++;
        hold = 0;
      end else begin
        hold = rvalid;
      end
      step();
    end
    chk("r_beats", 64'(beat), 64'(nbeats));
    // a further beat offered after rlast must be refused
    rvalid = 1; rlast = 0; rdata = $urandom; snk_ready = 1;
    #1;
    chk("done_pulse", done, 1);
    chk("done_resp", done_resp, exp_resp);
    chk("extra_rready", rready, 0);
    chk("extra_snk_valid", snk_valid, 0);
    step();
    rvalid = 0; snk_ready = 0;
    #1;
    chk("done_end", done, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    src_valid = 1; src_data = 0; src_strb = 0; snk_ready = 1;
    awready = 1; wready = 1; arready = 1;
    bid = 0; bresp = 0; bvalid = 1;
    rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 1;
    repeat (3) step();
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {awvalid, arvalid, wvalid, bready, rready, src_ready, snk_valid}, 0);
    chk("rst_done", done, 0);
    chk("rst_done_resp", done_resp, 0);
    rst = 0;
    src_valid = 0; awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; snk_ready = 0;
    step();

    do_write(32'h100, 8'd3, 4'h5, 2'b00, 0, 1, -1);
    do_read(32'h200, 8'd7, 4'h3, 8, 0, 1, 0);
    do_read(32'hFF8, 8'd3, 4'h1, 4, 0, 0, 0);
    do_read(32'h400, 8'd3, 4'h2, 2, 0, 0, 2);
    do_write(32'h800, 8'd7, 4'h7, 2'b00, 0, 0, 2);
    do_write(32'h842, 8'd1, 4'h6, 2'b01, 0, 0, -1);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      logic [7:0]  l;
      logic [3:0]  id;
      int nb;
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[11:0] = 12'(4096 - $urandom_range(1, 80));
      l = 8'($urandom_range(0, 15));
      id = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, l, id, 2'($urandom), ($urandom_range(0, 7) == 0), 0, -1);
      end else begin
        nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, int'(l) + 1) : int'(l) + 1;
        do_read(a, l, id, nb, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
